// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Sole owner of the register-file write port. Arbitrates between three
// write-back requesters (ALU result pair, load, move/incr/decr) and emits at
// most one register write per cycle.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   alu_valid/alu_r/alu_s    ALU pair: alu_r -> reg 0x0, alu_s -> reg 0x1
//   alu_ready                ALU request accepted this cycle
//   ld_valid/ld_dst/ld_data  load write-back request
//   ld_ready                 load request accepted this cycle
//   mv_valid/mv_dst/mv_data  move write-back request
//   mv_ready                 move request accepted this cycle
//   wr_en/wr_addr/wr_data    registered register-file write port
//   rd_addr                  register the decoder is about to read
//   rd_hazard                rd_addr is the target of the write at the next edge
//   err                      one-cycle pulse: LD/MV to reg 0x0/0x1/0xF dropped
//   busy                     second ALU write pending or write on the port
//
// Build option:
//   WB_RR_EN  round-robin arbitration over ALU, LD, MV instead of the
//             default fixed priority ALU > LD > MV.
module regfile_wb_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic [7:0] alu_r,
  input  logic [7:0] alu_s,
  output logic       alu_ready,
  input  logic       ld_valid,
  input  logic [3:0] ld_dst,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       mv_valid,
  input  logic [3:0] mv_dst,
  input  logic [7:0] mv_data,
  output logic       mv_ready,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic       rd_hazard,
  output logic       err,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_ALU2} state_t;

  state_t     state;
  logic [7:0] alu_s_q;
  logic       idle;
  logic       grant_alu, grant_ld, grant_mv;
  logic       sel_any;
  logic [3:0] sel_dst;
  logic [7:0] sel_data;
  logic       sel_prot;

  // Reg 0x0/0x1 belong to the ALU pair and 0xF is the PC.
  function automatic logic is_protected(input logic [3:0] a);
    return (a == 4'h0) || (a == 4'h1) || (a == 4'hF);
  endfunction

  // rst_n is folded in so every ready drops the moment reset asserts.
  assign idle = rst_n && (state == S_IDLE);

`ifdef WB_RR_EN
  typedef enum logic [1:0] {P_ALU, P_LD, P_MV} ptr_t;
  ptr_t rr_ptr;

  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    grant_mv  = 1'b0;
    if (idle) begin
      case (rr_ptr)
        P_LD: begin
          if (ld_valid)       grant_ld  = 1'b1;
          else if (mv_valid)  grant_mv  = 1'b1;
          else if (alu_valid) grant_alu = 1'b1;
        end
        P_MV: begin
          if (mv_valid)       grant_mv  = 1'b1;
          else if (alu_valid) grant_alu = 1'b1;
          else if (ld_valid)  grant_ld  = 1'b1;
        end
        default: begin
          if (alu_valid)      grant_alu = 1'b1;
          else if (ld_valid)  grant_ld  = 1'b1;
          else if (mv_valid)  grant_mv  = 1'b1;
        end
      endcase
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= P_ALU;
    end else if (grant_alu) begin
      rr_ptr <= P_LD;
    end else if (grant_ld) begin
      rr_ptr <= P_MV;
    end else if (grant_mv) begin
      rr_ptr <= P_ALU;
    end
  end
`else
  always_comb begin
    grant_alu = idle && alu_valid;
    grant_ld  = idle && ld_valid && !alu_valid;
    grant_mv  = idle && mv_valid && !alu_valid && !ld_valid;
  end
`endif

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;
  assign mv_ready  = grant_mv;

  always_comb begin
    sel_any  = grant_ld || grant_mv;
    sel_dst  = grant_ld ? ld_dst  : mv_dst;
    sel_data = grant_ld ? ld_data : mv_data;
    sel_prot = is_protected(sel_dst);
  end

  // Only writes that will really reach the port count; dropped requests
  // never produce a value the decoder could wait for.
  always_comb begin
    rd_hazard = 1'b0;
    if (grant_alu && ((rd_addr == 4'h0) || (rd_addr == 4'h1)))
      rd_hazard = 1'b1;
    if ((state == S_ALU2) && (rd_addr == 4'h1))
      rd_hazard = 1'b1;
    if (sel_any && !sel_prot && (rd_addr == sel_dst))
      rd_hazard = 1'b1;
  end

  assign busy = (state == S_ALU2) || wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
      alu_s_q <= '0;
    end else begin
      case (state)
        S_ALU2: begin
          wr_en   <= 1'b1;
          wr_addr <= 4'h1;
          wr_data <= alu_s_q;
          err     <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          wr_en <= 1'b0;
          err   <= 1'b0;
          if (grant_alu) begin
            wr_en   <= 1'b1;
            wr_addr <= 4'h0;
            wr_data <= alu_r;
            alu_s_q <= alu_s;
            state   <= S_ALU2;
          end else if (sel_any) begin
            if (sel_prot) begin
              err <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= sel_dst;
              wr_data <= sel_data;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a write-back scoreboard.
module tb_regfile_wb_sched;

  logic       clk;
  logic       rst_n;
  logic       alu_valid;
  logic [7:0] alu_r, alu_s;
  logic       alu_ready;
  logic       ld_valid;
  logic [3:0] ld_dst;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       mv_valid;
  logic [3:0] mv_dst;
  logic [7:0] mv_data;
  logic       mv_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic       rd_hazard;
  logic       err;
  logic       busy;

  regfile_wb_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_r     (alu_r),
    .alu_s     (alu_s),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_dst    (ld_dst),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .mv_valid  (mv_valid),
    .mv_dst    (mv_dst),
    .mv_data   (mv_data),
    .mv_ready  (mv_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_hazard (rd_hazard),
    .err       (err),
    .busy      (busy)
  );

  typedef struct {
    int         due;
    bit         is_err;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic bit prot(input logic [3:0] a);
    return (a == 4'h0) || (a == 4'h1) || (a == 4'hF);
  endfunction

  // One request cycle: apply inputs, check readies/hazard, queue expected writes.
  task automatic drive(input logic av, input logic [7:0] r, input logic [7:0] s,
                       input logic lv, input logic [3:0] ldd, input logic [7:0] ldv,
                       input logic mvv, input logic [3:0] mvd, input logic [7:0] mvdat,
                       input logic [3:0] rd,
                       input logic e_ar, input logic e_lr, input logic e_mr,
                       input logic e_hz, input string tag);
    alu_valid = av;  alu_r = r;    alu_s = s;
    ld_valid  = lv;  ld_dst = ldd; ld_data = ldv;
    mv_valid  = mvv; mv_dst = mvd; mv_data = mvdat;
    rd_addr   = rd;
    #1;
    chk({tag, "_alu_ready"}, alu_ready, e_ar);
    chk({tag, "_ld_ready"},  ld_ready,  e_lr);
    chk({tag, "_mv_ready"},  mv_ready,  e_mr);
    chk({tag, "_rd_hazard"}, rd_hazard, e_hz);
    if (e_ar) begin
      q.push_back('{due: cyc + 1, is_err: 1'b0, addr: 4'h0, data: r});
      q.push_back('{due: cyc + 2, is_err: 1'b0, addr: 4'h1, data: s});
    end
    if (e_lr) begin
      if (prot(ldd)) q.push_back('{due: cyc + 1, is_err: 1'b1, addr: ldd, data: ldv});
      else           q.push_back('{due: cyc + 1, is_err: 1'b0, addr: ldd, data: ldv});
    end
    if (e_mr) begin
      if (prot(mvd)) q.push_back('{due: cyc + 1, is_err: 1'b1, addr: mvd, data: mvdat});
      else           q.push_back('{due: cyc + 1, is_err: 1'b0, addr: mvd, data: mvdat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [3:0] rd, input logic e_hz, input string tag);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, rd,
          1'b0, 1'b0, 1'b0, e_hz, tag);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or err.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL missing_wb: got nothing, expected addr 0x%0h data 0x%0h err %0b at cycle %0d (now %0d)",
                   q[0].addr, q[0].data, q[0].is_err, q[0].due, cyc);
          void'(q.pop_front());
        end
        if (wr_en || err) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_wb: got wr_en %0b err %0b addr 0x%0h data 0x%0h, expected idle (cycle %0d)",
                     wr_en, err, wr_addr, wr_data, cyc);
          end else begin
            mon_e = q.pop_front();
            chk("wb_cycle", cyc, mon_e.due);
            chk("wb_err", err, mon_e.is_err);
            chk("wb_en", wr_en, !mon_e.is_err);
            if (!mon_e.is_err) begin
              chk("wb_addr", wr_addr, mon_e.addr);
              chk("wb_data", wr_data, mon_e.data);
            end
          end
        end
        if (wr_en) chk("wb_not_pc", (wr_addr == 4'hF), 1'b0);
      end
    end
  end

  logic [2:0] arb_exp [6];

  initial begin
`ifdef WB_RR_EN
    arb_exp = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000};
`else
    arb_exp = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000};
`endif
    // Reset state, with every requester asking.
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_r = 8'h12; alu_s = 8'h34;
    ld_valid  = 1'b1; ld_dst = 4'h2; ld_data = 8'h56;
    mv_valid  = 1'b1; mv_dst = 4'h3; mv_data = 8'h78;
    rd_addr   = 4'h0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'h0);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_hazard", rd_hazard, 1'b0);
    chk("rst_ready", {alu_ready, ld_ready, mv_ready}, 3'b000);
    repeat (2) @(posedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0; mv_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle(4'h0, 1'b0, "idle0");

    // ALU pair 0x3C/0xA5; readies all low while the second write is pending.
    drive(1'b1, 8'h3C, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0,
          1'b1, 1'b0, 1'b0, 1'b1, "alu_acc");
    drive(1'b1, 8'hEE, 8'hDD, 1'b1, 4'h5, 8'h99, 1'b1, 4'h6, 8'h88, 4'h1,
          1'b0, 1'b0, 1'b0, 1'b1, "alu2_hold");
    chk("alu2_busy", busy, 1'b1);
    idle_cycle(4'h2, 1'b0, "after_alu");

    // LD and MV together: LD first, MV the following cycle.
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'h6, 8'h55, 1'b1, 4'h7, 8'h11, 4'h6,
          1'b0, 1'b1, 1'b0, 1'b1, "ld_win");
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 8'h11, 4'h6,
          1'b0, 1'b0, 1'b1, 1'b0, "mv_next");
    idle_cycle(4'h7, 1'b0, "after_mv");

    // Protected destinations: accepted, dropped, err pulse.
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'h20, 4'hF,
          1'b0, 1'b0, 1'b1, 1'b0, "mv_pc");
    idle_cycle(4'hF, 1'b0, "pc_err");
    idle_cycle(4'hF, 1'b0, "pc_err_gone");
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'h0, 8'h77, 1'b0, 4'h0, 8'h00, 4'h0,
          1'b0, 1'b1, 1'b0, 1'b0, "ld_r0");
    idle_cycle(4'h0, 1'b0, "r0_err");

    // Hazard on a register other than 0x1 during S_ALU2.
    drive(1'b1, 8'h5A, 8'hC3, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h1,
          1'b1, 1'b0, 1'b0, 1'b1, "alu_b");
    idle_cycle(4'h2, 1'b0, "alu2_rd2");
    idle_cycle(4'h1, 1'b0, "after_alu_b");

    // Reset one cycle after an ALU accept aborts the reg 0x1 write.
    drive(1'b1, 8'h99, 8'h66, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0,
          1'b1, 1'b0, 1'b0, 1'b1, "rst_alu");
    alu_valid = 1'b0; rd_addr = 4'h1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 1'b0);
    chk("abort_wr_addr", wr_addr, 4'h0);
    chk("abort_wr_data", wr_data, 8'h00);
    chk("abort_err", err, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd_hazard", rd_hazard, 1'b0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle(4'h1, 1'b0, "post_rst");
    chk("post_rst_busy", busy, 1'b0);

    // All three requesters held valid for six cycles.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'h11, 8'h22, 1'b1, 4'h3, 8'h33, 1'b1, 4'h4, 8'h44, 4'h9,
            arb_exp[k][2], arb_exp[k][1], arb_exp[k][0], 1'b0, $sformatf("arb%0d", k));
    end
    repeat (3) idle_cycle(4'h0, 1'b0, "drain");
    chk("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
